// File: rtl/bcd_to_bin.sv
// bcd_to_bin: iterative N-digit packed BCD to binary converter, one digit per clock, MSD first.
// All outputs are registered; valid/ready handshakes on both sides.
module bcd_to_bin #(
  parameter int N = 25,
  parameter int W = 84
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_valid,
  output logic           i_ready,
  input  logic [N*4-1:0] i,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [W-1:0]   o,
  output logic           err,
  output logic           ovf
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t           state_q;
  logic [N*4-1:0]   sr_q;
  logic [W-1:0]     acc_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       d;
  logic [W+3:0]     sum;
  assign d   = sr_q[N*4-1 -: 4];
  // acc*10 + d never exceeds W+4 bits, so the top nibble is the overflow indicator
  assign sum = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {{W{1'b0}}, d};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      i_ready <= 1'b1;
      o_valid <= 1'b0;
      o       <= '0;
      err     <= 1'b0;
      ovf     <= 1'b0;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          sr_q    <= i;
          acc_q   <= '0;
          cnt_q   <= CW'(N - 1);
          err     <= 1'b0;
          ovf     <= 1'b0;
          o       <= '0;
          i_ready <= 1'b0;
          state_q <= CONV;
        end
        CONV: begin
          acc_q <= sum[W-1:0];
          sr_q  <= sr_q << 4;
          cnt_q <= cnt_q - 1'b1;
          if (d > 4'd9) err <= 1'b1;
          if (|sum[W+3:W]) ovf <= 1'b1;
          if (cnt_q == '0) begin
            o       <= sum[W-1:0];
            o_valid <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: if (o_ready) begin
          o_valid <= 1'b0;
          i_ready <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: directed checks of bcd_to_bin at N=25/W=84, N=4/W=14 and N=4/W=13.
module tb_bcd_to_bin;
  logic clk = 1'b0, rst_n = 1'b0;
  logic v25, r25, ir25, ov25, e25, f25;
  logic [99:0] i25;
  logic [83:0] o25;
  logic v4, r4, ir14, ov14, e14, f14, ir13, ov13, e13, f13;
  logic [15:0] i4;
  logic [13:0] o14;
  logic [12:0] o13;
  int checks = 0, failures = 0;
  int ov_at, ir_at, idx, n_out, lat;
  int acc_t [3];
  logic [15:0] vals [3];
  logic [13:0] exp14 [3];
  logic [12:0] exp13 [3];
  logic f13_exp [3];

  always #5 clk = ~clk;

  bcd_to_bin #(.N(25), .W(84)) u25 (.clk(clk), .rst_n(rst_n), .i_valid(v25), .i_ready(ir25), .i(i25),
    .o_valid(ov25), .o_ready(r25), .o(o25), .err(e25), .ovf(f25));
  bcd_to_bin #(.N(4), .W(14)) u14 (.clk(clk), .rst_n(rst_n), .i_valid(v4), .i_ready(ir14), .i(i4),
    .o_valid(ov14), .o_ready(r4), .o(o14), .err(e14), .ovf(f14));
  bcd_to_bin #(.N(4), .W(13)) u13 (.clk(clk), .rst_n(rst_n), .i_valid(v4), .i_ready(ir13), .i(i4),
    .o_valid(ov13), .o_ready(r4), .o(o13), .err(e13), .ovf(f13));

  task automatic chk(input string tag, input logic [99:0] obs, input logic [99:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ov14(output int k);
    k = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ov14) begin k = n; break; end
    end
  endtask

  initial begin
    v25 = 0; r25 = 1; i25 = '0; v4 = 0; r4 = 1; i4 = '0;
    vals = '{16'h9999, 16'h0000, 16'h1234};
    exp14 = '{14'h270F, 14'h0000, 14'h04D2};
    exp13 = '{13'h070F, 13'h0000, 13'h04D2};
    f13_exp = '{1'b1, 1'b0, 1'b0};
    #12;
    chk("rst_ir25", ir25, 1); chk("rst_ov25", ov25, 0); chk("rst_o25", o25, 0);
    chk("rst_err25", e25, 0); chk("rst_ovf25", f25, 0); chk("rst_ir14", ir14, 1);
    @(negedge clk) rst_n = 1;
    // N=25: latency and result
    @(negedge clk); i25 = 100'h12345678; v25 = 1; chk("ir25_idle", ir25, 1);
    @(posedge clk); #1 v25 = 0; chk("ir25_fall", ir25, 0);
    ov_at = 0; ir_at = 0;
    for (int k = 1; k <= 40 && ir_at == 0; k++) begin
      @(posedge clk); #1;
      if (ov25 && ov_at == 0) begin
        ov_at = k;
        chk("o25", o25, 84'hBC614E); chk("err25", e25, 0); chk("ovf25", f25, 0);
      end
      if (ir25) ir_at = k;
    end
    chk("lat25", ov_at, 25); chk("irlow25", ir_at, 26); chk("ov25_fall", ov25, 0);
    // N=4 back-to-back with o_ready high
    idx = 0; n_out = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      i4 = (idx < 3) ? vals[idx] : 16'h0;
      v4 = (idx < 3);
      if (ov14 && n_out < 3) begin
        chk("b2b_o14", o14, exp14[n_out]); chk("b2b_o13", o13, exp13[n_out]);
        chk("b2b_ovf13", f13, f13_exp[n_out]); chk("b2b_ovf14", f14, 0);
        n_out++;
      end
      if (ir14 && v4) begin acc_t[idx] = c; idx++; end
    end
    v4 = 0;
    chk("b2b_outs", n_out, 3); chk("b2b_accs", idx, 3);
    chk("b2b_gap1", acc_t[1] - acc_t[0], 6); chk("b2b_gap2", acc_t[2] - acc_t[1], 6);
    // invalid digit
    @(negedge clk); i4 = 16'h12A4; v4 = 1; chk("err_ir", ir14, 1);
    @(posedge clk); #1 v4 = 0;
    wait_ov14(lat);
    chk("err_lat", lat, 4); chk("err_o14", o14, 14'h518); chk("err_e14", e14, 1);
    chk("err_f14", f14, 0); chk("err_o13", o13, 13'h518); chk("err_f13", f13, 0);
    // backpressure
    @(posedge clk);
    @(negedge clk); r4 = 0; i4 = 16'h0500; v4 = 1; chk("bp_ir", ir14, 1);
    @(posedge clk); #1 v4 = 0;
    wait_ov14(lat);
    chk("bp_lat", lat, 4);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_ov", ov14, 1); chk("bp_o", o14, 14'h1F4); chk("bp_ir_low", ir14, 0);
    end
    @(negedge clk) r4 = 1;
    @(negedge clk) r4 = 0;
    chk("rel_ov", ov14, 0); chk("rel_ir", ir14, 1); chk("rel_o_held", o14, 14'h1F4);
    // asynchronous reset mid-conversion
    @(negedge clk); i4 = 16'hA999; v4 = 1; r4 = 1;
    @(posedge clk); #1 v4 = 0;
    @(posedge clk); @(posedge clk); #2;
    chk("mid_err_set", e14, 1); chk("mid_ir_low", ir14, 0);
    rst_n = 0; #1;
    chk("ar_ir", ir14, 1); chk("ar_ov", ov14, 0); chk("ar_o", o14, 0);
    chk("ar_err", e14, 0); chk("ar_ovf", f14, 0);
    @(negedge clk) rst_n = 1;
    @(negedge clk); i4 = 16'h0042; v4 = 1; chk("post_ir", ir14, 1);
    @(posedge clk); #1 v4 = 0;
    wait_ov14(lat);
    chk("post_lat", lat, 4); chk("post_o", o14, 14'h2A); chk("post_err", e14, 0);
    @(posedge clk); #1;
    chk("post_ov_fall", ov14, 0); chk("post_ir_rise", ir14, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
